control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM for a single-bus CPU datapath.
// Sequences fetch (F0-F3) and execute (E0-E5) steps and emits one-cycle
// datapath, memory and register-select strobes decoded from the state and
// the opcode latched at the end of F3.
//   Clock, Clear   : clock and synchronous active-high reset
//   IR             : instruction register contents, opcode in IR[31:27]
//   CON            : branch condition, used only in E3 of brzr
//   Stop           : pause request, honoured only in F0
//   strobes        : PCin .. LOout, one bit each
//   ctrl           : ALU operation (0 ADD, 1 SUB, 2 AND, 3 OR, 4 INC)
//   Run            : high in every state except RST and HALT
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        wren,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        InPortout,
  output logic        outPortEnable,
  output logic        conInput,
  output logic        HIout,
  output logic        LOout,
  output logic [3:0]  ctrl,
  output logic        Run
);

  typedef enum logic [3:0] {
    RST, F0, F1, F2, F3, E0, E1, E2, E3, E4, E5, HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BRZR = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_INC = 4'h4;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] op_q;
  logic       is_rrr;
  logic       is_mem;
  logic       unused_ir_bits;

  always_comb unused_ir_bits = ^IR[26:0];

  always_comb begin
    is_rrr = (op_q == OP_ADD) || (op_q == OP_SUB) ||
             (op_q == OP_AND) || (op_q == OP_OR);
    is_mem = (op_q == OP_LD) || (op_q == OP_ST);
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Clear) state <= RST;
    else       state <= state_nxt;
  end

  // Opcode is captured on the same edge that loads IR's successor state E0
  always_ff @(posedge Clock) begin
    if (Clear)            op_q <= OP_NOP;
    else if (state == F3) op_q <= IR[31:27];
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RST:  state_nxt = F0;
      F0:   state_nxt = Stop ? F0 : F1;
      F1:   state_nxt = F2;
      F2:   state_nxt = F3;
      F3:   state_nxt = E0;
      E0: begin
        if (op_q == OP_HALT)
          state_nxt = HALT;
        else if (is_rrr || is_mem || op_q == OP_ADDI || op_q == OP_BRZR)
          state_nxt = E1;
        else
          state_nxt = F0;
      end
      E1:   state_nxt = E2;
      E2:   state_nxt = (is_mem || op_q == OP_BRZR) ? E3 : F0;
      E3:   state_nxt = is_mem ? E4 : F0;
      E4:   state_nxt = (op_q == OP_LD) ? E5 : F0;
      E5:   state_nxt = F0;
      HALT: state_nxt = HALT;
      default: state_nxt = RST;
    endcase
  end

  // Output decode
  always_comb begin
    PCin = 1'b0;  PCout = 1'b0;  IncPC = 1'b0;  IRin = 1'b0;
    Yin = 1'b0;   MARin = 1'b0;  MDRin = 1'b0;  MDRout = 1'b0;
    Read = 1'b0;  wren = 1'b0;   Gra = 1'b0;    Grb = 1'b0;
    Grc = 1'b0;   Rin = 1'b0;    Rout = 1'b0;   BAout = 1'b0;
    Zlowin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
    outPortEnable = 1'b0; conInput = 1'b0; HIout = 1'b0; LOout = 1'b0;
    ctrl = ALU_ADD;
    Run  = (state != RST) && (state != HALT);
    case (state)
      F0: if (!Stop) begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; ctrl = ALU_INC;
      end
      F1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      F2: begin Read = 1'b1; MDRin = 1'b1; end
      F3: begin MDRout = 1'b1; IRin = 1'b1; end
      E0: begin
        if (is_rrr || is_mem || op_q == OP_ADDI) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; BAout = is_mem;
        end else begin
          case (op_q)
            OP_BRZR: begin Gra = 1'b1; Rout = 1'b1; conInput = 1'b1; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortEnable = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      E1: begin
        if (is_rrr) begin
          Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1;
          case (op_q)
            OP_SUB:  ctrl = ALU_SUB;
            OP_AND:  ctrl = ALU_AND;
            OP_OR:   ctrl = ALU_OR;
            default: ctrl = ALU_ADD;
          endcase
        end else if (op_q == OP_BRZR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          Cout = 1'b1; Zlowin = 1'b1;
        end
      end
      E2: begin
        if (op_q == OP_BRZR) begin
          Cout = 1'b1; Zlowin = 1'b1;
        end else if (is_mem) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      E3: begin
        if (op_q == OP_BRZR) begin
          Zlowout = 1'b1; PCin = CON;
        end else if (op_q == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else begin
          Read = 1'b1; MDRin = 1'b1;
        end
      end
      E4: begin
        if (op_q == OP_ST) wren = 1'b1;
        else begin Read = 1'b1; MDRin = 1'b1; end
      end
      E5: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: table of per-instruction
// output sequences plus hand-written Stop, Clear and halt sequences.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, CON, Stop;
  logic [31:0] IR;
  logic PCin, PCout, IncPC, IRin, Yin, MARin, MDRin, MDRout, Read, wren;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Zlowin, Zlowout, Cout, InPortout;
  logic outPortEnable, conInput, HIout, LOout, Run;
  logic [3:0] ctrl;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .wren(wren),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Zlowin(Zlowin), .Zlowout(Zlowout), .Cout(Cout), .InPortout(InPortout),
    .outPortEnable(outPortEnable), .conInput(conInput), .HIout(HIout),
    .LOout(LOout), .ctrl(ctrl), .Run(Run)
  );

  always #5 Clock = ~Clock;

  localparam logic [28:0] M_PCIN    = 29'd1 << 0;
  localparam logic [28:0] M_PCOUT   = 29'd1 << 1;
  localparam logic [28:0] M_INCPC   = 29'd1 << 2;
  localparam logic [28:0] M_IRIN    = 29'd1 << 3;
  localparam logic [28:0] M_YIN     = 29'd1 << 4;
  localparam logic [28:0] M_MARIN   = 29'd1 << 5;
  localparam logic [28:0] M_MDRIN   = 29'd1 << 6;
  localparam logic [28:0] M_MDROUT  = 29'd1 << 7;
  localparam logic [28:0] M_READ    = 29'd1 << 8;
  localparam logic [28:0] M_WREN    = 29'd1 << 9;
  localparam logic [28:0] M_GRA     = 29'd1 << 10;
  localparam logic [28:0] M_GRB     = 29'd1 << 11;
  localparam logic [28:0] M_GRC     = 29'd1 << 12;
  localparam logic [28:0] M_RIN     = 29'd1 << 13;
  localparam logic [28:0] M_ROUT    = 29'd1 << 14;
  localparam logic [28:0] M_BAOUT   = 29'd1 << 15;
  localparam logic [28:0] M_ZLOWIN  = 29'd1 << 16;
  localparam logic [28:0] M_ZLOWOUT = 29'd1 << 17;
  localparam logic [28:0] M_COUT    = 29'd1 << 18;
  localparam logic [28:0] M_INPORT  = 29'd1 << 19;
  localparam logic [28:0] M_OUTPORT = 29'd1 << 20;
  localparam logic [28:0] M_CONIN   = 29'd1 << 21;
  localparam logic [28:0] M_HIOUT   = 29'd1 << 22;
  localparam logic [28:0] M_LOOUT   = 29'd1 << 23;
  localparam logic [28:0] C_SUB     = 29'd1 << 24;
  localparam logic [28:0] C_AND     = 29'd2 << 24;
  localparam logic [28:0] C_OR      = 29'd3 << 24;
  localparam logic [28:0] C_INC     = 29'd4 << 24;
  localparam logic [28:0] M_RUN     = 29'd1 << 28;

  localparam logic [28:0] W_F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | C_INC | M_RUN;
  localparam logic [28:0] W_F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [28:0] W_F2 = M_READ | M_MDRIN | M_RUN;
  localparam logic [28:0] W_F3 = M_MDROUT | M_IRIN | M_RUN;

  logic [28:0] obs;
  logic [7:0]  bus;
  assign obs = {Run, ctrl, LOout, HIout, conInput, outPortEnable, InPortout,
                Cout, Zlowout, Zlowin, BAout, Rout, Rin, Grc, Grb, Gra, wren,
                Read, MDRout, MDRin, MARin, Yin, IRin, IncPC, PCout, PCin};
  assign bus = {PCout, MDRout, Rout, Zlowout, Cout, InPortout, HIout, LOout};

  typedef struct packed {
    logic [4:0]        op;
    logic              con;
    logic [3:0]        ne;  // number of execute cycles
    logic [5:0][28:0]  e;   // expected E0..E5 words, Run not included
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [4:0] op, input logic con, input logic [3:0] ne,
                              input logic [28:0] e0, input logic [28:0] e1,
                              input logic [28:0] e2, input logic [28:0] e3,
                              input logic [28:0] e4, input logic [28:0] e5);
    vec_t v;
    v.op = op; v.con = con; v.ne = ne;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3; v.e[4] = e4; v.e[5] = e5;
    return v;
  endfunction

  task automatic check(input string name, input logic [28:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: outputs got %h want %h", name, obs, want);
    end
    total++;
    if ($countones(bus) > 1) begin
      bad++;
      $display("FAIL %s onehot: bus drivers got %b want at most one high", name, bus);
    end
  endtask

  task automatic set_ir(input logic [4:0] op);
    IR = {op, 27'($urandom)};
  endtask

  task automatic step_check(input string name, input logic [28:0] want);
    @(negedge Clock);
    check(name, want);
  endtask

  initial begin
    logic [28:0] ldx0, ldx1, ldx2;
    ldx0 = M_GRB | M_ROUT | M_BAOUT | M_YIN;
    ldx1 = M_COUT | M_ZLOWIN;
    ldx2 = M_ZLOWOUT | M_MARIN;
    vecs.push_back(mk(5'b00011, 1'b0, 4'd3, M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZLOWIN,
                      M_ZLOWOUT|M_GRA|M_RIN, '0, '0, '0));
    vecs.push_back(mk(5'b00100, 1'b0, 4'd3, M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZLOWIN|C_SUB,
                      M_ZLOWOUT|M_GRA|M_RIN, '0, '0, '0));
    vecs.push_back(mk(5'b00101, 1'b0, 4'd3, M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZLOWIN|C_AND,
                      M_ZLOWOUT|M_GRA|M_RIN, '0, '0, '0));
    vecs.push_back(mk(5'b00110, 1'b0, 4'd3, M_GRB|M_ROUT|M_YIN, M_GRC|M_ROUT|M_ZLOWIN|C_OR,
                      M_ZLOWOUT|M_GRA|M_RIN, '0, '0, '0));
    vecs.push_back(mk(5'b01100, 1'b0, 4'd3, M_GRB|M_ROUT|M_YIN, M_COUT|M_ZLOWIN,
                      M_ZLOWOUT|M_GRA|M_RIN, '0, '0, '0));
    vecs.push_back(mk(5'b00000, 1'b0, 4'd6, ldx0, ldx1, ldx2, M_READ|M_MDRIN,
                      M_READ|M_MDRIN, M_MDROUT|M_GRA|M_RIN));
    vecs.push_back(mk(5'b00010, 1'b1, 4'd5, ldx0, ldx1, ldx2, M_GRA|M_ROUT|M_MDRIN,
                      M_WREN, '0));
    vecs.push_back(mk(5'b10010, 1'b0, 4'd4, M_GRA|M_ROUT|M_CONIN, M_PCOUT|M_YIN,
                      M_COUT|M_ZLOWIN, M_ZLOWOUT, '0, '0));
    vecs.push_back(mk(5'b10010, 1'b1, 4'd4, M_GRA|M_ROUT|M_CONIN, M_PCOUT|M_YIN,
                      M_COUT|M_ZLOWIN, M_ZLOWOUT|M_PCIN, '0, '0));
    vecs.push_back(mk(5'b10100, 1'b0, 4'd1, M_GRA|M_ROUT|M_PCIN, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b10110, 1'b0, 4'd1, M_INPORT|M_GRA|M_RIN, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b10111, 1'b0, 4'd1, M_GRA|M_ROUT|M_OUTPORT, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b11000, 1'b0, 4'd1, M_HIOUT|M_GRA|M_RIN, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b11001, 1'b0, 4'd1, M_LOOUT|M_GRA|M_RIN, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b11010, 1'b1, 4'd1, '0, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b00001, 1'b1, 4'd1, '0, '0, '0, '0, '0, '0));
    vecs.push_back(mk(5'b11111, 1'b0, 4'd1, '0, '0, '0, '0, '0, '0));

    // Reset
    Clear = 1'b1; Stop = 1'b0; CON = 1'b0; IR = '0;
    repeat (2) @(negedge Clock);
    check("reset", '0);
    Clear = 1'b0;

    // Table: each entry runs F0 through its last execute cycle
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      set_ir(vecs[i].op);
      CON = vecs[i].con;
      step_check($sformatf("vec%0d F0", i), W_F0);
      step_check($sformatf("vec%0d F1", i), W_F1);
      step_check($sformatf("vec%0d F2", i), W_F2);
      step_check($sformatf("vec%0d F3", i), W_F3);
      for (int unsigned k = 0; k < 32'(vecs[i].ne); k++)
        step_check($sformatf("vec%0d E%0d", i, k), vecs[i].e[k] | M_RUN);
    end

    // Stop held at F0 for 5 cycles, then released
    Stop = 1'b1;
    for (int unsigned k = 0; k < 5; k++)
      step_check($sformatf("stop hold %0d", k), M_RUN);
    Stop = 1'b0;
    step_check("stop release F1", W_F1);

    // Stop outside F0 is ignored for the whole add instruction
    Stop = 1'b1;
    set_ir(5'b00011);
    step_check("stop ignored F2", W_F2);
    step_check("stop ignored F3", W_F3);
    step_check("stop ignored E0", M_GRB | M_ROUT | M_YIN | M_RUN);
    step_check("stop ignored E1", M_GRC | M_ROUT | M_ZLOWIN | M_RUN);
    step_check("stop ignored E2", M_ZLOWOUT | M_GRA | M_RIN | M_RUN);
    Stop = 1'b0;

    // Clear during E1 of sub aborts before the Gra/Rin write-back
    set_ir(5'b00100);
    step_check("abort F0", W_F0);
    step_check("abort F1", W_F1);
    step_check("abort F2", W_F2);
    step_check("abort F3", W_F3);
    step_check("abort E0", M_GRB | M_ROUT | M_YIN | M_RUN);
    step_check("abort E1", M_GRC | M_ROUT | M_ZLOWIN | C_SUB | M_RUN);
    Clear = 1'b1;
    step_check("abort RST", '0);
    Clear = 1'b0;
    step_check("abort F0 again", W_F0);

    // halt: E0 then HALT with Run low until Clear
    set_ir(5'b11011);
    step_check("halt F1", W_F1);
    step_check("halt F2", W_F2);
    step_check("halt F3", W_F3);
    step_check("halt E0", M_RUN);
    for (int unsigned k = 0; k < 20; k++)
      step_check($sformatf("halted %0d", k), '0);
    Clear = 1'b1;
    step_check("halt clear RST", '0);
    Clear = 1'b0;
    step_check("halt clear F0", W_F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
